// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } ifq_state_e;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO holding {pc,instr} pairs; flush wins over push and pop.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, prefetch FIFO to decode.
// Optional IFQ_PERF_EN adds popped-instruction and starved-cycle counters.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
`ifdef IFQ_PERF_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic [XLEN-1:0]    out_pc
);

  localparam int OW = $clog2(MAX_OUT+1);
  localparam int FW = $clog2(DEPTH+1);
  localparam int W  = XLEN + INSTR_W;

  ifq_state_e      state_q, state_d;
  logic [XLEN-1:0] fetchPc_q, fetchPc_d, rspPc_q, rspPc_d, redirPc;
  logic [OW-1:0]   outCnt_q, outCnt_d, drop_q, drop_d, inflight;
  logic            reqPend_q, reqPend_d;
  logic            credit, reqHs, rspDecr, pushEn, popEn;
  logic [FW-1:0]   fifoCount;
  logic            fifoFull, fifoEmpty;
  logic [W-1:0]    headData;

  assign redirPc = redirect_pc & ~XLEN'(3);
  assign credit  = (outCnt_q < OW'(MAX_OUT)) && ((int'(fifoCount) + int'(outCnt_q)) < DEPTH);
  assign reqHs   = imem_req_valid && imem_req_ready;
  assign rspDecr = imem_rsp_valid && (outCnt_q != '0);
  assign inflight = outCnt_q - OW'(rspDecr);
  assign pushEn  = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign popEn   = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fetchPc_q <= RESET_PC;
      rspPc_q   <= RESET_PC;
      outCnt_q  <= '0;
      drop_q    <= '0;
      reqPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      rspPc_q   <= rspPc_d;
      outCnt_q  <= outCnt_d;
      drop_q    <= drop_d;
      reqPend_q <= reqPend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (inflight != '0) ? S_DRAIN : (fetch_en ? S_FETCH : S_IDLE);
    end else begin
      unique case (state_q)
        S_IDLE:  if (fetch_en) state_d = S_FETCH;
        S_FETCH: if (!fetch_en && outCnt_q == '0 && !reqPend_q) state_d = S_IDLE;
        S_DRAIN: if (drop_d == '0) state_d = fetch_en ? S_FETCH : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Drop counts the old-stream responses still owed to us after a redirect.
  always_comb begin
    fetchPc_d = fetchPc_q;
    rspPc_d   = rspPc_q;
    drop_d    = drop_q;
    outCnt_d  = inflight + OW'(reqHs);
    reqPend_d = imem_req_valid && !imem_req_ready;
    if (redirect_valid) begin
      fetchPc_d = redirPc;
      rspPc_d   = redirPc;
      drop_d    = inflight;
    end else begin
      if (reqHs)  fetchPc_d = fetchPc_q + XLEN'(PC_STEP);
      if (pushEn) rspPc_d   = rspPc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - OW'(1);
    end
  end

  // A request that has been raised stays up until accepted; only a redirect withdraws it.
  always_comb begin
    imem_req_valid = !redirect_valid && (reqPend_q || (state_q == S_FETCH && fetch_en && credit));
    imem_req_addr  = fetchPc_q;
    out_valid      = !fifoEmpty;
    out_instr      = fifoEmpty ? NOP_INSTR : headData[INSTR_W-1:0];
    out_pc         = fifoEmpty ? '0 : headData[W-1:INSTR_W];
  end

  ifq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(W)
  ) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (pushEn),
    .pop_i  (popEn),
    .flush_i(redirect_valid),
    .data_i ({rspPc_q, imem_rsp_data}),
    .data_o (headData),
    .count_o(fifoCount),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

`ifdef IFQ_PERF_EN
  logic [31:0] perfFetch_q, perfStall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetch_q <= '0;
      perfStall_q <= '0;
    end else begin
      if (popEn) perfFetch_q <= perfFetch_q + 32'd1;
      if (out_ready && !out_valid && state_q != S_IDLE) perfStall_q <= perfStall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perfFetch_q;
  assign perf_stall_cnt = perfStall_q;
`endif

  assert property (@(posedge clk) disable iff (!rst_n) !(pushEn && fifoFull && !popEn));
  assert property (@(posedge clk) disable iff (!rst_n) outCnt_q <= OW'(MAX_OUT));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed, table-driven bench for ifetch_queue with an in-order imem model of programmable latency.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fetch_en = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
`ifdef IFQ_PERF_EN
  logic [31:0]     perf_fetch_cnt, perf_stall_cnt;
`endif

  int vecCount = 0;
  int missCount = 0;
  int memLat = 1;
  int cyc = 0;

  typedef struct {
    logic            fe, rdy, orr, rv;
    logic [XLEN-1:0] rpc;
    logic            eReqV;
    logic [XLEN-1:0] eAddr;
    logic            eOutV;
    logic [XLEN-1:0] ePc;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } memReq_t;

  memReq_t memQ[$];
  vec_t    tbl[18];

  ifetch_queue #(.XLEN(XLEN), .DEPTH(4), .MAX_OUT(2), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
`ifdef IFQ_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [XLEN-1:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  function automatic vec_t mk(input logic fe, input logic rdy, input logic orr, input logic rv,
                              input logic [XLEN-1:0] rpc, input logic eReqV,
                              input logic [XLEN-1:0] eAddr, input logic eOutV,
                              input logic [XLEN-1:0] ePc);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.orr = orr; v.rv = rv; v.rpc = rpc;
    v.eReqV = eReqV; v.eAddr = eAddr; v.eOutV = eOutV; v.ePc = ePc;
    return v;
  endfunction

  // Memory model: samples the handshake late in the cycle, answers in order after memLat cycles.
  initial begin
    logic            hs;
    logic [XLEN-1:0] hsAddr;
    forever begin
      @(negedge clk);
      #3;
      hs = rst_n && imem_req_valid && imem_req_ready;
      hsAddr = imem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        memQ.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
      end else begin
        if (hs) memQ.push_back('{hsAddr, cyc - 1 + memLat});
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = memWord(memQ[0].addr);
          void'(memQ.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data = '0;
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    fetch_en = v.fe;
    imem_req_ready = v.rdy;
    out_ready = v.orr;
    redirect_valid = v.rv;
    redirect_pc = v.rpc;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    logic bad;
    #1;
    bad = 1'b0;
    vecCount++;
    if (imem_req_valid !== v.eReqV) begin
      $display("[TB] FAIL %s req_valid got=%0b want=%0b", tag, imem_req_valid, v.eReqV);
      bad = 1'b1;
    end
    if (imem_req_addr !== v.eAddr) begin
      $display("[TB] FAIL %s req_addr got=%0h want=%0h", tag, imem_req_addr, v.eAddr);
      bad = 1'b1;
    end
    if (out_valid !== v.eOutV) begin
      $display("[TB] FAIL %s out_valid got=%0b want=%0b", tag, out_valid, v.eOutV);
      bad = 1'b1;
    end
    if (v.eOutV && out_pc !== v.ePc) begin
      $display("[TB] FAIL %s out_pc got=%0h want=%0h", tag, out_pc, v.ePc);
      bad = 1'b1;
    end
    if (v.eOutV && out_instr !== memWord(v.ePc)) begin
      $display("[TB] FAIL %s out_instr got=%0h want=%0h", tag, out_instr, memWord(v.ePc));
      bad = 1'b1;
    end
    if (bad) missCount++;
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  // Holds reset with fetch enabled, checks the reset outputs, then releases with inputs quiet.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    fetch_en = 1'b1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    vecCount++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== '0 || out_valid !== 1'b0 ||
        out_instr !== NOP_INSTR || out_pc !== '0) begin
      $display("[TB] FAIL reset got=%0b/%0h/%0b/%0h/%0h want=0/0/0/13/0", imem_req_valid,
               imem_req_addr, out_valid, out_instr, out_pc);
      missCount++;
    end
    @(negedge clk);
    fetch_en = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Streaming with a 1-cycle memory, then a decode stall filling all four slots, then release.
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 'h0,  0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 1, 'h0,  0, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 1, 'h4,  0, 0);
    tbl[3]  = mk(1, 1, 1, 0, 0, 1, 'h8,  1, 'h0);
    tbl[4]  = mk(1, 1, 1, 0, 0, 1, 'hC,  1, 'h4);
    tbl[5]  = mk(1, 1, 1, 0, 0, 1, 'h10, 1, 'h8);
    tbl[6]  = mk(1, 1, 1, 0, 0, 1, 'h14, 1, 'hC);
    tbl[7]  = mk(1, 1, 1, 0, 0, 1, 'h18, 1, 'h10);
    tbl[8]  = mk(1, 1, 0, 0, 0, 1, 'h1C, 1, 'h14);
    tbl[9]  = mk(1, 1, 0, 0, 0, 1, 'h20, 1, 'h14);
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 'h24, 1, 'h14);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 'h24, 1, 'h14);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 'h24, 1, 'h14);
    tbl[13] = mk(1, 1, 1, 0, 0, 0, 'h24, 1, 'h14);
    tbl[14] = mk(1, 1, 1, 0, 0, 1, 'h24, 1, 'h18);
    tbl[15] = mk(1, 1, 1, 0, 0, 1, 'h28, 1, 'h1C);
    tbl[16] = mk(1, 1, 1, 0, 0, 1, 'h2C, 1, 'h20);
    tbl[17] = mk(1, 1, 1, 0, 0, 1, 'h30, 1, 'h24);

    memLat = 1;
    doReset();
    for (int i = 0; i < 18; i++) runVec($sformatf("stream[%0d]", i), tbl[i]);

    // Redirect to 0x1002 while two requests are outstanding (3-cycle memory).
    memLat = 3;
    doReset();
    runVec("redir.c0", mk(1, 1, 1, 0, 0, 0, 'h0, 0, 0));
    runVec("redir.c1", mk(1, 1, 1, 0, 0, 1, 'h0, 0, 0));
    runVec("redir.c2", mk(1, 1, 1, 0, 0, 1, 'h4, 0, 0));
    runVec("redir.c3", mk(1, 1, 1, 1, 'h1002, 0, 'h8, 0, 0));
    runVec("redir.c4", mk(1, 1, 1, 0, 0, 0, 'h1000, 0, 0));
    runVec("redir.c5", mk(1, 1, 1, 0, 0, 0, 'h1000, 0, 0));
    runVec("redir.c6", mk(1, 1, 1, 0, 0, 1, 'h1000, 0, 0));
    runVec("redir.c7", mk(1, 1, 1, 0, 0, 1, 'h1004, 0, 0));
    runVec("redir.c8", mk(1, 1, 1, 0, 0, 0, 'h1008, 0, 0));
    runVec("redir.c9", mk(1, 1, 1, 0, 0, 0, 'h1008, 0, 0));
    runVec("redir.c10", mk(1, 1, 1, 0, 0, 1, 'h1008, 1, 'h1000));

    // Memory refuses for five cycles, then fetch_en drops and the stage must return to idle.
    memLat = 1;
    doReset();
    runVec("hold.c0", mk(1, 0, 1, 0, 0, 0, 'h0, 0, 0));
    for (int i = 1; i <= 5; i++) runVec($sformatf("hold.c%0d", i), mk(1, 0, 1, 0, 0, 1, 'h0, 0, 0));
    runVec("hold.c6", mk(1, 1, 1, 0, 0, 1, 'h0, 0, 0));
    runVec("hold.c7", mk(0, 1, 1, 0, 0, 0, 'h4, 0, 0));
    runVec("hold.c8", mk(0, 1, 1, 0, 0, 0, 'h4, 1, 'h0));
    runVec("hold.c9", mk(1, 1, 1, 0, 0, 0, 'h4, 0, 0));
    runVec("hold.c10", mk(1, 1, 1, 0, 0, 1, 'h4, 0, 0));

    // Redirect in the same cycle as a pop and an arriving response.
    doReset();
    runVec("coin.c0", mk(1, 1, 1, 0, 0, 0, 'h0, 0, 0));
    runVec("coin.c1", mk(1, 1, 1, 0, 0, 1, 'h0, 0, 0));
    runVec("coin.c2", mk(1, 1, 1, 0, 0, 1, 'h4, 0, 0));
    runVec("coin.c3", mk(1, 1, 1, 1, 'h200, 0, 'h8, 1, 'h0));
    runVec("coin.c4", mk(1, 1, 1, 0, 0, 1, 'h200, 0, 0));
    runVec("coin.c5", mk(1, 1, 1, 0, 0, 1, 'h204, 0, 0));
    runVec("coin.c6", mk(1, 1, 1, 0, 0, 1, 'h208, 1, 'h200));

`ifdef IFQ_PERF_EN
    // Three starved cycles (c1..c3) then ten pops (c4..c13), counters read at c14.
    doReset();
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 2; i < 14; i++) applyStimulus(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    vecCount++;
    if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd3) begin
      $display("[TB] FAIL perf got=%0d/%0d want=10/3", perf_fetch_cnt, perf_stall_cnt);
      missCount++;
    end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      $display("[TB] FAIL perf_reset got=%0d/%0d want=0/0", perf_fetch_cnt, perf_stall_cnt);
      missCount++;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
